// File: rtl/udp_pkg.sv
// Shared definitions for the UDP receive/transmit layers: header and IP-user
// field offsets, protocol constants and the receive FSM encoding.
package udp_pkg;

    localparam int HDR_SRC_MSB   = 63;
    localparam int HDR_DST_MSB   = 47;
    localparam int HDR_LEN_MSB   = 31;
    localparam int HDR_CSUM_MSB  = 15;

    localparam int IPU_LEN_MSB   = 55;
    localparam int IPU_FLAG_MSB  = 39;
    localparam int IPU_PROTO_MSB = 36;
    localparam int IPU_OFF_MSB   = 28;
    localparam int IPU_ID_MSB    = 15;

    localparam logic [7:0]  UDP_PROTO     = 8'd17;
    localparam logic [15:0] UDP_HDR_BYTES = 16'd8;

    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;
    localparam int IP_USER_W   = 56;
    localparam int UDP_USER_W  = 32;
    localparam int SKID_W      = AXIS_DATA_W + UDP_USER_W + AXIS_KEEP_W + 1;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_PASS = 2'd1,
        S_DROP = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] udp_len;
        logic [15:0] csum;
    } udp_hdr_t;

    typedef struct packed {
        logic [15:0] ip_len;
        logic [2:0]  flag;
        logic [7:0]  protocol;
        logic [12:0] offset;
        logic [15:0] id;
    } ip_user_t;

    function automatic udp_hdr_t unpack_hdr(input logic [AXIS_DATA_W-1:0] d);
        udp_hdr_t h;
        h.src_port = d[HDR_SRC_MSB  -: 16];
        h.dst_port = d[HDR_DST_MSB  -: 16];
        h.udp_len  = d[HDR_LEN_MSB  -: 16];
        h.csum     = d[HDR_CSUM_MSB -: 16];
        return h;
    endfunction

    function automatic ip_user_t unpack_ipu(input logic [IP_USER_W-1:0] u);
        ip_user_t p;
        p.ip_len   = u[IPU_LEN_MSB   -: 16];
        p.flag     = u[IPU_FLAG_MSB  -: 3];
        p.protocol = u[IPU_PROTO_MSB -: 8];
        p.offset   = u[IPU_OFF_MSB   -: 13];
        p.id       = u[IPU_ID_MSB    -: 16];
        return p;
    endfunction

endpackage

// File: rtl/udp_rx_if.sv
// AXI-Stream bundle used on both sides of the UDP layer; user width differs
// between the IP side (56) and the application side (32).
interface udp_rx_if #(
    parameter int DATA_W = 64,
    parameter int USER_W = 56,
    parameter int KEEP_W = DATA_W / 8
);
    logic [DATA_W-1:0] data;
    logic [USER_W-1:0] user;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic              valid;
    logic              ready;

    modport master (output data, user, keep, last, valid, input ready);
    modport slave  (input data, user, keep, last, valid, output ready);
endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry register slice: full throughput, registered upstream ready,
// output stable while stalled.
module axis_skid_buf #(
    parameter int W = 105
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready
);
    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;
    logic         r_main_vld;
    logic         r_skid_vld;
    logic         w_push;
    logic         w_main_free;

    assign o_ready     = ~r_skid_vld;
    assign o_data      = r_main;
    assign o_valid     = r_main_vld;
    assign w_push      = i_valid & ~r_skid_vld;
    assign w_main_free = ~r_main_vld | i_ready;

    // The skid slot only fills when the output is stalled; it drains first so order is kept.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_main     <= '0;
            r_skid     <= '0;
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_vld) begin
                r_main     <= r_skid;
                r_main_vld <= 1'b1;
                r_skid_vld <= 1'b0;
            end else if (w_push) begin
                r_main     <= i_data;
                r_main_vld <= 1'b1;
            end else begin
                r_main_vld <= 1'b0;
            end
        end else if (w_push) begin
            r_skid     <= i_data;
            r_skid_vld <= 1'b1;
        end
    end

endmodule

// File: rtl/udp_rx.sv
// UDP receive layer: validates the header beat, filters on destination port,
// strips the header and forwards the payload with {src_port, payload_len}.
module udp_rx
    import udp_pkg::*;
#(
    parameter logic [15:0] P_LOCAL_UDP_PORT = 16'h0808,
    parameter bit          P_PORT_FILTER_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_dymanic_local_port,
    input  logic        i_dymanic_local_valid,
    udp_rx_if.slave     s_axis_ip,
    udp_rx_if.master    m_axis_user,
    output logic [15:0] o_rx_pkt_cnt,
    output logic [15:0] o_drop_cnt
);
    rx_state_e             r_state;
    rx_state_e             w_state_nxt;
    logic [15:0]           r_local_port;
    logic [UDP_USER_W-1:0] r_user;
    logic [15:0]           r_rx_cnt;
    logic [15:0]           r_drop_cnt;

    udp_hdr_t              w_hdr;
    ip_user_t              w_ipu;
    logic                  w_hdr_ok;
    logic                  w_ready;
    logic                  w_fwd_done;
    logic                  w_drop;
    logic                  w_unused;

    logic                  w_skid_valid;
    logic                  w_skid_ready;
    logic [SKID_W-1:0]     w_skid_in;
    logic [SKID_W-1:0]     w_skid_out;
    logic                  w_skid_out_valid;

    assign w_hdr    = unpack_hdr(s_axis_ip.data);
    assign w_ipu    = unpack_ipu(s_axis_ip.user);
    assign w_unused = ^{w_hdr.csum, w_ipu.flag, w_ipu.offset, w_ipu.id};

    assign w_hdr_ok = (w_ipu.protocol == UDP_PROTO)
                    && (w_hdr.udp_len == w_ipu.ip_len)
                    && (w_hdr.udp_len > UDP_HDR_BYTES)
                    && (!P_PORT_FILTER_EN || (w_hdr.dst_port == r_local_port))
                    && !s_axis_ip.last;

    // Acceptance is derived from valid plus the per-state ready source, which avoids a loop through s_axis_ip.ready.
    always_comb begin
        w_state_nxt  = r_state;
        w_ready      = 1'b1;
        w_skid_valid = 1'b0;
        w_fwd_done   = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            S_HDR: begin
                if (s_axis_ip.valid) begin
                    if (w_hdr_ok) begin
                        w_state_nxt = S_PASS;
                    end else begin
                        w_drop = 1'b1;
                        if (!s_axis_ip.last) w_state_nxt = S_DROP;
                    end
                end
            end
            S_PASS: begin
                w_ready      = w_skid_ready;
                w_skid_valid = s_axis_ip.valid;
                if (s_axis_ip.valid && w_skid_ready && s_axis_ip.last) begin
                    w_fwd_done  = 1'b1;
                    w_state_nxt = S_HDR;
                end
            end
            S_DROP: begin
                if (s_axis_ip.valid && s_axis_ip.last) w_state_nxt = S_HDR;
            end
            default: w_state_nxt = S_HDR;
        endcase
    end

    assign s_axis_ip.ready = w_ready & ~i_rst;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_HDR;
        else       r_state <= w_state_nxt;
    end

    // A port update in the header cycle lands after the header has been judged.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                      r_local_port <= P_LOCAL_UDP_PORT;
        else if (i_dymanic_local_valid) r_local_port <= i_dymanic_local_port;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_user <= '0;
        end else if (r_state == S_HDR && s_axis_ip.valid && w_hdr_ok) begin
            r_user <= {w_hdr.src_port, w_hdr.udp_len - UDP_HDR_BYTES};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_cnt   <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_fwd_done) r_rx_cnt   <= r_rx_cnt + 16'd1;
            if (w_drop)     r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign o_rx_pkt_cnt = r_rx_cnt;
    assign o_drop_cnt   = r_drop_cnt;

    // User travels with every beat so a following header can reload r_user safely.
    assign w_skid_in = {s_axis_ip.data, r_user, s_axis_ip.keep, s_axis_ip.last};

    axis_skid_buf #(.W(SKID_W)) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_data  (w_skid_in),
        .i_valid (w_skid_valid),
        .o_ready (w_skid_ready),
        .o_data  (w_skid_out),
        .o_valid (w_skid_out_valid),
        .i_ready (m_axis_user.ready)
    );

    assign {m_axis_user.data, m_axis_user.user, m_axis_user.keep, m_axis_user.last} = w_skid_out;
    assign m_axis_user.valid = w_skid_out_valid;

endmodule

// File: tb/tb_udp_rx.sv
// Scoreboard bench for udp_rx: directed packets push expected beats, monitors
// pop and compare on every output handshake.
module tb_udp_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] dyn_port = 16'h0;
    logic        dyn_vld  = 1'b0;
    logic [63:0] d_data   = '0;
    logic [55:0] d_user   = '0;
    logic [7:0]  d_keep   = '0;
    logic        d_last   = 1'b0;
    logic        d_valid  = 1'b0;
    logic        sel      = 1'b0;
    logic        mrdy     = 1'b1;
    int          rmode    = 0;
    logic [15:0] rx0, dr0, rx1, dr1;

    always #5 clk = ~clk;

    udp_rx_if #(.DATA_W(64), .USER_W(56)) ip0 ();
    udp_rx_if #(.DATA_W(64), .USER_W(56)) ip1 ();
    udp_rx_if #(.DATA_W(64), .USER_W(32)) mo0 ();
    udp_rx_if #(.DATA_W(64), .USER_W(32)) mo1 ();

    assign ip0.data = d_data;  assign ip0.user = d_user;  assign ip0.keep = d_keep;
    assign ip0.last = d_last;  assign ip0.valid = d_valid & ~sel;
    assign ip1.data = d_data;  assign ip1.user = d_user;  assign ip1.keep = d_keep;
    assign ip1.last = d_last;  assign ip1.valid = d_valid & sel;
    assign mo0.ready = mrdy;
    assign mo1.ready = 1'b1;

    udp_rx #(.P_LOCAL_UDP_PORT(16'h0808), .P_PORT_FILTER_EN(1'b1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_dymanic_local_port(dyn_port), .i_dymanic_local_valid(dyn_vld),
        .s_axis_ip(ip0), .m_axis_user(mo0),
        .o_rx_pkt_cnt(rx0), .o_drop_cnt(dr0)
    );

    udp_rx #(.P_LOCAL_UDP_PORT(16'h0808), .P_PORT_FILTER_EN(1'b0)) dut_nf (
        .i_clk(clk), .i_rst(rst),
        .i_dymanic_local_port(16'h0), .i_dymanic_local_valid(1'b0),
        .s_axis_ip(ip1), .m_axis_user(mo1),
        .o_rx_pkt_cnt(rx1), .o_drop_cnt(dr1)
    );

    typedef logic [104:0] beat_t;
    beat_t q0[$];
    beat_t q1[$];
    int nvec = 0, nerr = 0, stalls = 0;
    int erx0 = 0, edr0 = 0, erx1 = 0, edr1 = 0;
    logic [7:0] salt = 8'h00;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        nvec++;
        nerr++;
        $display("FAIL %s", nm);
    endtask

    // Downstream ready: 0 = always ready, 1 = toggling, 2 = held low.
    initial forever begin
        @(posedge clk); #1;
        case (rmode)
            1:       mrdy = ~mrdy;
            2:       mrdy = 1'b0;
            default: mrdy = 1'b1;
        endcase
    end

    initial begin : mon0
        beat_t act, pv;
        bit    st;
        st = 0; pv = '0;
        forever begin
            @(negedge clk);
            act = {mo0.data, mo0.user, mo0.keep, mo0.last};
            if (rst) st = 0;
            else begin
                if (st) chk("hold0", {mo0.valid, act}, {1'b1, pv});
                if (mo0.valid && mo0.ready) begin
                    if (q0.size() == 0) flag($sformatf("extra0: unexpected beat %0h", act));
                    else chk("beat0", act, q0.pop_front());
                end
                st = mo0.valid && !mo0.ready;
                pv = act;
            end
        end
    end

    initial begin : mon1
        beat_t act;
        forever begin
            @(negedge clk);
            act = {mo1.data, mo1.user, mo1.keep, mo1.last};
            if (!rst && mo1.valid) begin
                if (q1.size() == 0) flag($sformatf("extra1: unexpected beat %0h", act));
                else chk("beat1", act, q1.pop_front());
            end
        end
    end

    task automatic beat(input logic [63:0] dt, input logic [55:0] us,
                        input logic [7:0] kp, input logic lst);
        int   n;
        logic ok;
        n = 0;
        d_data = dt; d_user = us; d_keep = kp; d_last = lst; d_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = sel ? ip1.ready : ip0.ready;
            @(posedge clk); #1;
            if (!ok) stalls++;
            n++;
        end while (!ok && n < 200);
        if (!ok) flag("accept_timeout");
    endtask

    task automatic pkt(input logic [15:0] src, input logic [15:0] dst,
                       input logic [15:0] ulen, input logic [15:0] iplen,
                       input logic [7:0] proto, input int npay,
                       input logic [7:0] lkeep, input bit pass, input bit dyn);
        logic [55:0] us;
        logic [63:0] dt;
        logic [7:0]  kp;
        logic [15:0] plen;
        us   = {iplen, 3'b010, proto, 13'd0, 16'h00AB};
        plen = ulen - 16'd8;
        dyn_vld = dyn;
        beat({src, dst, ulen, 16'h0000}, us, 8'hFF, npay == 0);
        dyn_vld = 1'b0;
        for (int i = 0; i < npay; i++) begin
            dt = {8{8'(salt + 8'((i + 1) * 17))}};
            kp = (i == npay - 1) ? lkeep : 8'hFF;
            if (pass) begin
                if (sel) q1.push_back({dt, src, plen, kp, i == npay - 1});
                else     q0.push_back({dt, src, plen, kp, i == npay - 1});
            end
            beat(dt, 56'h0, kp, i == npay - 1);
        end
        salt = salt + 8'd1;
        if (sel) begin if (pass) erx1++; else edr1++; end
        else     begin if (pass) erx0++; else edr0++; end
    endtask

    task automatic drain(input string nm);
        int n;
        d_valid = 1'b0;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_q_left"}, q0.size() + q1.size(), 0);
        chk({nm, "_rx0"}, rx0, 16'(erx0));
        chk({nm, "_drop0"}, dr0, 16'(edr0));
        chk({nm, "_rx1"}, rx1, 16'(erx1));
        chk({nm, "_drop1"}, dr1, 16'(edr1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", ip0.ready, 0);
        chk("rst_m_out", {mo0.valid, mo0.data, mo0.user, mo0.keep, mo0.last}, 0);
        chk("rst_cnt", {rx0, dr0}, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("s_ready_after_rst", ip0.ready, 1);

        // basic forward: user {1234, 0010}
        pkt(16'h1234, 16'h0808, 16'h0018, 16'h0018, 8'd17, 2, 8'hFF, 1, 0);
        drain("basic");

        // port filter drop, ready must stay high throughout
        stalls = 0;
        pkt(16'h1234, 16'h0909, 16'h0018, 16'h0018, 8'd17, 2, 8'hFF, 0, 0);
        chk("drop_stalls", stalls, 0);
        drain("portdrop");

        // length mismatch, wrong protocol, header-only then back-to-back good packet
        pkt(16'h1234, 16'h0808, 16'h0015, 16'h0018, 8'd17, 2, 8'hFF, 0, 0);
        pkt(16'h1234, 16'h0808, 16'h0018, 16'h0018, 8'd6,  2, 8'hFF, 0, 0);
        pkt(16'h1234, 16'h0808, 16'h0008, 16'h0008, 8'd17, 0, 8'hFF, 0, 0);
        pkt(16'h5678, 16'h0808, 16'h0018, 16'h0018, 8'd17, 2, 8'hFF, 1, 0);
        drain("baddrops");

        // 13-byte payload, partial last keep
        pkt(16'hABCD, 16'h0808, 16'h0015, 16'h0015, 8'd17, 2, 8'hF8, 1, 0);
        drain("partial");

        // toggling backpressure, back-to-back packets
        rmode = 1;
        pkt(16'h1111, 16'h0808, 16'h0058, 16'h0058, 8'd17, 10, 8'hFF, 1, 0);
        pkt(16'h2222, 16'h0808, 16'h0020, 16'h0020, 8'd17, 3,  8'hC0, 1, 0);
        drain("backpressure");
        rmode = 0;

        // port update coincident with header: old port applies to that packet
        dyn_port = 16'h4000;
        pkt(16'h3333, 16'h0808, 16'h0018, 16'h0018, 8'd17, 2, 8'hFF, 1, 1);
        pkt(16'h4444, 16'h4000, 16'h0018, 16'h0018, 8'd17, 2, 8'hFF, 1, 0);
        pkt(16'h5555, 16'h0808, 16'h0018, 16'h0018, 8'd17, 2, 8'hFF, 0, 0);
        drain("dynport");

        // filter disabled instance forwards any destination
        sel = 1'b1;
        pkt(16'h6666, 16'h0909, 16'h0018, 16'h0018, 8'd17, 2, 8'hFF, 1, 0);
        drain("nofilter");
        sel = 1'b0;

        // reset while payload is held in the skid stage
        rmode = 2;
        @(posedge clk); #1;
        beat({16'h7777, 16'h0808, 16'h0018, 16'h0000}, {16'h0018, 3'b010, 8'd17, 13'd0, 16'h00AB}, 8'hFF, 1'b0);
        beat(64'hDEAD_BEEF_0000_0001, 56'h0, 8'hFF, 1'b0);
        beat(64'hDEAD_BEEF_0000_0002, 56'h0, 8'hFF, 1'b0);
        d_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_m_out", {mo0.valid, mo0.data, mo0.user, mo0.keep, mo0.last}, 0);
        chk("midrst_s_ready", ip0.ready, 0);
        chk("midrst_cnt", {rx0, dr0, rx1, dr1}, 0);
        erx0 = 0; edr0 = 0; erx1 = 0; edr1 = 0;
        rmode = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        pkt(16'h8888, 16'h0808, 16'h0018, 16'h0018, 8'd17, 2, 8'hFF, 1, 0);
        drain("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/udp_rx.md
# udp_rx

Receive-side UDP layer of the 10G Ethernet stack. It sits between the IP receive layer and the user application. It accepts IP-payload beats whose first 64-bit beat is the UDP header, validates and filters the datagram, strips the header and forwards the payload on a user AXI-Stream with the source port and payload byte length attached.

## Interface
Parameters:
- P_LOCAL_UDP_PORT, 16'h0808, reset value of the accepted destination port.
- P_PORT_FILTER_EN, 1, 1 = drop datagrams whose dst port ≠ local port; 0 = accept any port.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_dymanic_local_port  in  16  new local port value.
- i_dymanic_local_valid  in  1  loads i_dymanic_local_port.
- s_axis_ip_data  in  64  IP payload; beat 0 = {src_port[63:48], dst_port[47:32], udp_len[31:16], csum[15:0]}.
- s_axis_ip_user  in  56  {ip_payload_len[55:40], flag[39:37], protocol[36:29], offset[28:16], id[15:0]}, sampled on beat 0.
- s_axis_ip_keep  in  8  byte enables, MSB-first (8'hFF full, 8'hF0 = 4 bytes).
- s_axis_ip_last  in  1  final beat.
- s_axis_ip_valid  in  1  beat valid.
- s_axis_ip_ready  out  1  beat accepted when valid & ready.
- m_axis_user_data  out  64  UDP payload.
- m_axis_user_user  out  32  {src_port[31:16], payload_len[15:0]}, constant for the whole packet.
- m_axis_user_keep  out  8  byte enables.
- m_axis_user_last  out  1  final payload beat.
- m_axis_user_valid  out  1  payload beat valid.
- m_axis_user_ready  in  1  downstream ready.
- o_rx_pkt_cnt  out  16  datagrams forwarded; wraps.
- o_drop_cnt  out  16  datagrams dropped; wraps.

## Operation
- Local port register: resets to P_LOCAL_UDP_PORT and loads on i_dymanic_local_valid. A packet uses the register value at the moment its header beat is accepted.
- FSM states:
  - S_HDR (reset state).
  - S_PASS.
  - S_DROP.
- S_HDR:
  - s_axis_ip_ready = 1.
  - On an accepted header beat, evaluate:
    - a. protocol == 8'd17;
    - b. udp_len == ip_payload_len;
    - c. udp_len > 8;
    - d. filter disabled or dst_port == local port;
    - e. !last.
  - All true: latch {src_port, udp_len-8} into the user register, go to S_PASS.
  - Otherwise: increment o_drop_cnt. If last was asserted, stay in S_HDR; else go to S_DROP.
- S_PASS:
  - s_axis_ip_ready = ready of the output skid stage.
  - Each accepted beat is forwarded unchanged (data, keep, last).
  - On the accepted last beat: increment o_rx_pkt_cnt, go to S_HDR.
- S_DROP:
  - s_axis_ip_ready = 1.
  - Discard beats; go to S_HDR on the accepted last beat.
- The checksum is ignored; a value of 0 is legal.
- Payload keep/last are taken from the input and are not recomputed from udp_len.
- Output reset values:
  - m_axis_user_data, user and keep are 0.
  - m_axis_user_last and valid are 0.
  - s_axis_ip_ready = 0 during reset, 1 from the first cycle after reset release (S_HDR).
  - Both counters are 0.

## Timing
- Latency: a payload beat accepted at edge n is presented on m_axis_user at edge n+1 when the output is empty.
- Skid stage: 2-entry, full throughput. No bubble under continuous valid/ready.
- Backpressure: while m_axis_user_valid & !m_axis_user_ready, data, user, keep and last hold stable. s_axis_ip_ready deasserts once the skid is full, never combinationally from m_axis_user_ready.
- Back-to-back packets: the header of packet k+1 may arrive the cycle after last of packet k. The header beat is never forwarded.
- Simultaneous events: i_dymanic_local_valid in the same cycle as a header beat means the old port is used.
- Counters:
  - increment by exactly 1 per packet;
  - 16'hFFFF wraps to 0;
  - a forward and a drop cannot occur in the same cycle.
- Reset mid-packet: FSM returns to S_HDR, skid is emptied, the partial packet is lost without any output. Upstream must restart at a header beat.

## Structure
- Shared package `udp_pkg`:
  - UDP header field offsets;
  - IP user field offsets;
  - UDP_PROTO = 8'd17;
  - UDP_HDR_BYTES = 8;
  - FSM state encoding.
- Sub-module `axis_skid_buf`: a 2-entry register slice, parameterised on total payload width (64+32+8+1). Reusable by the TX path.

## Test plan
- Header {0x1234, 0x0808, 0x0018, 0}, user len 0x0018, proto 17, then payload beats 0x11.., 0x22.. (keep FF, last) -> two output beats with user {0x1234, 0x0010}, keep FF, last on beat 2; o_rx_pkt_cnt=1.
- Same packet with dst_port 0x0909, filter on -> s_axis_ip_ready held 1, no m_axis valid; o_drop_cnt=1. With P_PORT_FILTER_EN=0 -> forwarded.
- udp_len 0x0015 vs ip len 0x0018 -> dropped. Separately, a header-only packet (udp_len 8, last on beat 0) -> dropped, FSM stays in S_HDR.
- Payload of 13 bytes: last beat keep F8 -> output last beat keep F8, user payload_len 0x000D.
- m_axis_user_ready toggling 1010… over a 10-beat packet, with back-to-back second packet -> every beat delivered in order, no duplication, correct user per packet.
- i_dymanic_local_valid with 0x4000 in the header cycle, then the next packet to 0x4000 -> first packet judged against the old port, second accepted. Assert i_rst mid-PASS -> outputs go to 0 immediately, counters 0.
